// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first, through one shared
// full-subtract cell built from two NAND-only half subtractors and a borrow flop.

module half_subtractor_nand (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    logic n1, n2, n3;

    // d = x ^ y from four NANDs; borrow = ~x & y reuses n3 = ~(~x & y).
    assign n1 = ~(x & y);
    assign n2 = ~(x & n1);
    assign n3 = ~(y & n1);
    assign d  = ~(n2 & n3);
    assign bo = ~(n3 & n3);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sa, sb, sr, sr_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d1, b1, d, b2, bnext;
    logic             accept, last;

    half_subtractor_nand u_hs0 (.x(sa[0]), .y(sb[0]), .d(d1), .bo(b1));
    half_subtractor_nand u_hs1 (.x(d1),    .y(borrow), .d(d), .bo(b2));

    // OR of the two partial borrows, kept in NAND form.
    assign bnext  = ~(~b1 & ~b2);
    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_sr_one
            assign sr_next = d;
        end else begin : g_sr_many
            assign sr_next = {d, sr[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: all datapath flops are reset, so an aborted operation leaves no stale result behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            sr     <= sr_next;
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            borrow <= bnext;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff <= sr_next;
                bout <= bnext;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random bench for serial_subtractor_ctrl (WIDTH=8 and WIDTH=1 instances),
// with scoreboard queues filled at start and drained on each done pulse.

module tb_serial_subtractor_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;

    int checks   = 0;
    int failures = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done8) begin
                if (q8.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL sb8_unexpected_done observed=done expected=no_done");
                end else begin
                    check("sb8_result", {bout8, diff8}, q8.pop_front());
                end
            end
            if (done1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL sb1_unexpected_done observed=done expected=no_done");
                end else begin
                    check("sb1_result", {bout1, diff1}, q1.pop_front());
                end
            end
            if (busy8 || done8) check("excl8", busy8 & done8, 0);
            if (busy1 || done1) check("excl1", busy1 & done1, 0);
        end
    end

    task automatic go8(input logic [7:0] x, input logic [7:0] y);
        @(posedge clk); #1;
        a8 = x; b8 = y; start8 = 1'b1;
        q8.push_back({1'b0, x} - {1'b0, y});
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input string tag);
        int n = 0;
        while (!done8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, done8, 1);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y);
        go8(x, y);
        wait_done8("op8_done");
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n, ndone;
        logic [7:0] t2_a [3] = '{8'd5, 8'd0, 8'd255};
        logic [7:0] t2_b [3] = '{8'd10, 8'd1, 8'd255};
        logic [7:0] t2_d [3] = '{8'd251, 8'd255, 8'd0};
        logic       t2_bo[3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] x, y;
        logic [0:0] x1, y1;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        #12;
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_diff8", diff8, 0);
        check("rst_bout8", bout8, 0);
        check("rst_busy1", busy1, 0);
        check("rst_diff1", diff1, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: single op, busy width and done pulse
        go8(8'd200, 8'd55);
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("t1_busy_cycles", n, 8);
        check("t1_done", done8, 1);
        @(posedge clk); #1;
        check("t1_done_pulse", done8, 0);
        check("t1_idle_busy", busy8, 0);
        check("t1_diff", diff8, 145);
        check("t1_bout", bout8, 0);

        // T2: borrow cases and equal operands
        for (int i = 0; i < 3; i++) begin
            op8(t2_a[i], t2_b[i]);
            check("t2_diff", diff8, t2_d[i]);
            check("t2_bout", bout8, t2_bo[i]);
        end

        // T3: start during RUN is ignored
        go8(8'd9, 8'd3);
        repeat (3) begin @(posedge clk); #1; end
        a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        start8 = 1'b0;
        check("t3_still_busy", busy8, 1);
        wait_done8("t3_done");
        check("t3_diff", diff8, 6);
        check("t3_bout", bout8, 0);
        @(posedge clk); #1;
        check("t3_no_requeue", busy8, 0);

        // T4: start held high, back-to-back operations
        @(posedge clk); #1;
        a8 = 8'd20; b8 = 8'd7; start8 = 1'b1;
        q8.push_back(9'd13);
        ndone = 0;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
            if (cyc == 9) begin
                check("t4_done_cyc9", done8, 1);
                a8 = 8'd7; b8 = 8'd20;
                q8.push_back(9'h1F3);
            end
            if (cyc == 18) begin
                check("t4_done_cyc18", done8, 1);
                start8 = 1'b0;
            end
        end
        check("t4_done_count", ndone, 2);
        check("t4_diff", diff8, 243);
        check("t4_bout", bout8, 1);

        // T5: asynchronous reset mid-RUN
        go8(8'd50, 8'd20);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        check("t5_busy", busy8, 0);
        check("t5_done", done8, 0);
        check("t5_diff", diff8, 0);
        check("t5_bout", bout8, 0);
        q8.delete();
        q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5_idle_busy", busy8, 0);
        check("t5_idle_done", done8, 0);
        op8(8'd77, 8'd33);
        check("t5_next_diff", diff8, 44);
        check("t5_next_bout", bout8, 0);

        // T6: random operands on both widths
        for (int i = 0; i < 1000; i++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            x1 = 1'($urandom);
            y1 = 1'($urandom);
            @(posedge clk); #1;
            a8 = x;  b8 = y;  start8 = 1'b1;
            a1 = x1; b1 = y1; start1 = 1'b1;
            q8.push_back({1'b0, x} - {1'b0, y});
            q1.push_back({1'b0, x1} - {1'b0, y1});
            @(posedge clk); #1;
            start8 = 1'b0;
            start1 = 1'b0;
            wait_done8("t6_done");
        end

        repeat (3) begin @(posedge clk); #1; end
        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
